// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART block receiver.
// Character FSM states, fixed data width and the parity-bit function.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    // Parity bit that makes data plus parity even (odd=0) or odd (odd=1).
    function automatic logic parity_bit(input logic [UART_DATA_BITS-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_char.sv
// Single-character UART receiver: synchroniser, mid-bit timing and character FSM.
// Optional parity stage compiled in with UART_RX_PARITY_EN.
module uart_rx_char
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 22,
    parameter int PARITY_ODD   = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      data_in,
    output logic                      char_valid,
    output logic [UART_DATA_BITS-1:0] char_data,
    output logic                      char_err,
    output logic                      busy
);

    localparam int             CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]     LAST_BIT  = 3'(UART_DATA_BITS - 1);

    logic                      sync_reg, rxs_reg, rxs_prev_reg;
    rx_state_t                 state_reg, state_next;
    logic [CW-1:0]             cnt_reg, cnt_next;
    logic [2:0]                bit_reg, bit_next;
    logic [UART_DATA_BITS-1:0] data_reg, data_next;
    logic                      tick, par_ok;

`ifdef UART_RX_PARITY_EN
    logic par_reg, par_next;
    assign par_ok = (par_reg == parity_bit(data_reg, PARITY_ODD != 0));
`else
    // Parity sense has no meaning without the parity stage.
    logic unused_parity;
    assign unused_parity = (PARITY_ODD != 0);
    assign par_ok        = 1'b1;
`endif

    assign tick      = (cnt_reg == '0);
    assign char_data = data_reg;
    assign busy      = (state_reg != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg     <= 1'b1;
            rxs_reg      <= 1'b1;
            rxs_prev_reg <= 1'b1;
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            bit_reg      <= '0;
            data_reg     <= '0;
`ifdef UART_RX_PARITY_EN
            par_reg      <= 1'b0;
`endif
        end else begin
            sync_reg     <= data_in;
            rxs_reg      <= sync_reg;
            rxs_prev_reg <= rxs_reg;
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            bit_reg      <= bit_next;
            data_reg     <= data_next;
`ifdef UART_RX_PARITY_EN
            par_reg      <= par_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = tick ? cnt_reg : cnt_reg - 1'b1;
        bit_next   = bit_reg;
        data_next  = data_reg;
        char_valid = 1'b0;
        char_err   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_next   = par_reg;
`endif
        unique case (state_reg)
            IDLE: begin
                // A falling edge only counts if the line was high the cycle before,
                // so a held-low line (break) never re-triggers.
                cnt_next = '0;
                if (rxs_prev_reg && !rxs_reg) begin
                    state_next = START;
                    cnt_next   = HALF_LOAD;
                end
            end
            START: begin
                if (tick) begin
                    state_next = rxs_reg ? IDLE : DATA;
                    cnt_next   = FULL_LOAD;
                    bit_next   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    data_next = {rxs_reg, data_reg[UART_DATA_BITS-1:1]};
                    cnt_next  = FULL_LOAD;
                    bit_next  = bit_reg + 1'b1;
                    if (bit_reg == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    par_next   = rxs_reg;
                    cnt_next   = FULL_LOAD;
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_next = IDLE;
                    if (rxs_reg && par_ok) char_valid = 1'b1;
                    else                   char_err   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_rx_block.sv
// UART receiver that packs BYTES_PER_BLOCK characters into one wide word with a
// valid/ready handshake and sticky overrun flag. Parity option: UART_RX_PARITY_EN.
module uart_rx_block
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT    = 22,
    parameter int DATA_BITS       = 8,
    parameter int BYTES_PER_BLOCK = 8,
    parameter int PARITY_ODD      = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 data_in,
    output logic [DATA_BITS*BYTES_PER_BLOCK-1:0] data_out,
    output logic                                 block_valid,
    input  logic                                 block_ready,
    output logic                                 rx_busy,
    output logic                                 frame_err,
    output logic                                 overrun
);

    localparam int LANE_W  = DATA_BITS;
    localparam int BLOCK_W = DATA_BITS * BYTES_PER_BLOCK;
    localparam int CNT_W   = (BYTES_PER_BLOCK > 1) ? $clog2(BYTES_PER_BLOCK) : 1;

    logic                      char_valid, char_err, char_busy;
    logic [UART_DATA_BITS-1:0] char_data;
    logic [CNT_W-1:0]          byte_cnt_reg;
    logic [BLOCK_W-1:0]        asm_reg, merged, data_out_reg;
    logic                      block_valid_reg, overrun_reg;
    logic                      last_lane, block_done, block_load;

    uart_rx_char #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .PARITY_ODD   (PARITY_ODD)
    ) u_char (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_err   (char_err),
        .busy       (char_busy)
    );

    // Assembly word with the incoming character dropped into the current lane.
    for (genvar gi = 0; gi < BYTES_PER_BLOCK; gi++) begin : g_lane
        assign merged[gi*LANE_W +: LANE_W] = (byte_cnt_reg == CNT_W'(gi))
                                           ? char_data
                                           : asm_reg[gi*LANE_W +: LANE_W];
    end

    assign last_lane  = (byte_cnt_reg == CNT_W'(BYTES_PER_BLOCK - 1));
    assign block_done = char_valid && last_lane;
    // Accepting the old block on the same edge frees the output for the new one.
    assign block_load = block_done && (!block_valid_reg || block_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt_reg    <= '0;
            asm_reg         <= '0;
            data_out_reg    <= '0;
            block_valid_reg <= 1'b0;
            overrun_reg     <= 1'b0;
        end else begin
            if (char_err) begin
                byte_cnt_reg <= '0;
            end else if (char_valid) begin
                asm_reg      <= merged;
                byte_cnt_reg <= last_lane ? '0 : byte_cnt_reg + 1'b1;
            end

            if (block_load) begin
                data_out_reg    <= merged;
                block_valid_reg <= 1'b1;
            end else if (block_valid_reg && block_ready) begin
                block_valid_reg <= 1'b0;
            end

            if (block_done && !block_load) overrun_reg <= 1'b1;
        end
    end

    assign data_out    = data_out_reg;
    assign block_valid = block_valid_reg;
    assign overrun     = overrun_reg;
    assign frame_err   = char_err;
    assign rx_busy     = char_busy || (byte_cnt_reg != '0);

endmodule
